// File: rtl/cnn_layer_sequencer.sv
// cnn_layer_sequencer: steps one shared conv engine through NUM_LAYERS per window.
// Ports: window in (valid/ready, win_we), engine ctl (start/layer/src/done, buf_we), pixel out, status.
module cnn_layer_sequencer #(
  parameter int NUM_LAYERS     = 5,
  parameter int LAYER_W        = 3,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               eng_start,
  output logic [LAYER_W-1:0] eng_layer,
  output logic               eng_src_sel,
  input  logic               eng_done,
  output logic               buf_we,
  output logic               win_we,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               clr_err,
  output logic               busy,
  output logic               err_timeout,
  output logic [CNT_W-1:0]   pixel_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [LAYER_W-1:0] LAST  = LAYER_W'(NUM_LAYERS - 1);
  localparam logic [TW-1:0]      T_END = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    OUTPUT
  } state_t;

  state_t             state;
  logic [LAYER_W-1:0] layer;
  logic [TW-1:0]      timer;
  logic               armed;
  logic               accept;
  logic               timeout;

  // armed keeps in_ready low until the first edge after reset release
  assign in_ready    = armed & (state == IDLE);
  assign accept      = in_valid & in_ready;
  assign win_we      = accept;
  assign eng_start   = (state == START);
  assign eng_layer   = layer;
  assign eng_src_sel = (layer != '0);
  assign buf_we      = (state == WAIT) & eng_done & (layer != LAST);
  assign out_valid   = (state == OUTPUT);
  assign busy        = (state != IDLE);
  // a done in the terminal cycle wins over the timeout
  assign timeout     = (state == WAIT) & ~eng_done & (timer == T_END);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      layer       <= '0;
      timer       <= '0;
      armed       <= 1'b0;
      err_timeout <= 1'b0;
      pixel_count <= '0;
    end else begin
      armed <= 1'b1;
      if (timeout)
        err_timeout <= 1'b1;
      else if (clr_err)
        err_timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            layer <= '0;
            state <= START;
          end
        end
        START: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          timer <= timer + TW'(1);
          if (eng_done) begin
            if (layer == LAST) begin
              state <= OUTPUT;
            end else begin
              layer <= layer + LAYER_W'(1);
              state <= START;
            end
          end else if (timeout) begin
            layer <= '0;
            state <= IDLE;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            pixel_count <= pixel_count + CNT_W'(1);
            layer       <= '0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// tb_cnn_layer_sequencer: random windows, engine delays, hangs and stalls vs a timeline model.
// Ports: none (top-level bench).
module tb_cnn_layer_sequencer;

  localparam int NL = 5;
  localparam int LW = 3;
  localparam int TO = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic          eng_start;
  logic [LW-1:0] eng_layer;
  logic          eng_src_sel;
  logic          eng_done;
  logic          buf_we;
  logic          win_we;
  logic          out_valid;
  logic          out_ready;
  logic          clr_err;
  logic          busy;
  logic          err_timeout;
  logic [CW-1:0] pixel_count;

  cnn_layer_sequencer #(
    .NUM_LAYERS(NL),
    .LAYER_W(LW),
    .TIMEOUT_CYCLES(TO),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .eng_start(eng_start),
    .eng_layer(eng_layer),
    .eng_src_sel(eng_src_sel),
    .eng_done(eng_done),
    .buf_we(buf_we),
    .win_we(win_we),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .clr_err(clr_err),
    .busy(busy),
    .err_timeout(err_timeout),
    .pixel_count(pixel_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_cnt = 0;
  int exp_err = 0;
  int d [NL];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // h: layer that hangs (-1 none); ab: layer aborted by reset (-1 none)
  task automatic run_pixel(input int h, input int ab, input int stall,
                           input bit clr_at_to);
    int cyc;
    int lat;
    lat = 1;
    for (int i = 0; i < NL; i++) lat += 1 + d[i];
    @(negedge clk);
    in_valid = 1'b1;
    clr_err  = 1'b0;
    eng_done = 1'b0;
    #1;
    chk("acc_ready", in_ready, 1);
    chk("acc_win_we", win_we, 1);
    step();
    in_valid = 1'b0;
    cyc = 1;
    #1;
    chk("win_we_lo", win_we, 0);
    for (int i = 0; i < NL; i++) begin
      chk("start", eng_start, 1);
      chk("layer", eng_layer, i);
      chk("src_sel", eng_src_sel, 32'(i != 0));
      chk("busy", busy, 1);
      chk("ready_lo", in_ready, 0);
      if (i == ab) begin
        step();
        step();
        #2;
        reset = 1'b0;
        #1;
        chk("rst_start", eng_start, 0);
        chk("rst_layer", eng_layer, 0);
        chk("rst_src", eng_src_sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_ov", out_valid, 0);
        chk("rst_buf_we", buf_we, 0);
        chk("rst_cnt", pixel_count, 0);
        chk("rst_err", err_timeout, 0);
        exp_cnt = 0;
        exp_err = 0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rel_ready_lo", in_ready, 0);
        step();
        #1;
        chk("rel_ready", in_ready, 1);
        chk("rel_ov", out_valid, 0);
        chk("rel_cnt", pixel_count, 0);
        return;
      end
      if (i == h) begin
        for (int k = 1; k <= TO; k++) begin
          step();
          if (k == TO && clr_at_to) clr_err = 1'b1;
          #1;
          chk("hang_start", eng_start, 0);
          chk("hang_busy", busy, 1);
          chk("hang_err", err_timeout, exp_err);
        end
        step();
        clr_err = 1'b0;
        exp_err = 1;
        #1;
        chk("to_err", err_timeout, 1);
        chk("to_busy", busy, 0);
        chk("to_ready", in_ready, 1);
        chk("to_ov", out_valid, 0);
        chk("to_cnt", pixel_count, exp_cnt);
        return;
      end
      for (int k = 1; k <= d[i]; k++) begin
        step();
        cyc++;
        if (k == d[i]) eng_done = 1'b1;
        #1;
        chk("wait_start", eng_start, 0);
        chk("wait_ov", out_valid, 0);
        chk("wait_layer", eng_layer, i);
        chk("buf_we", buf_we, (k == d[i] && i < NL - 1) ? 1 : 0);
      end
      step();
      cyc++;
      eng_done = 1'b0;
      #1;
    end
    chk("ov", out_valid, 1);
    chk("latency", cyc, lat);
    chk("err_keep", err_timeout, exp_err);
    for (int s = 0; s < stall; s++) begin
      eng_done = 1'($urandom_range(0, 1));
      #1;
      chk("stall_buf_we", buf_we, 0);
      step();
      eng_done = 1'b0;
      #1;
      chk("stall_ov", out_valid, 1);
      chk("stall_ready", in_ready, 0);
      chk("stall_cnt", pixel_count, exp_cnt);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    exp_cnt = (exp_cnt + 1) % (1 << CW);
    #1;
    chk("cnt", pixel_count, exp_cnt);
    chk("post_ready", in_ready, 1);
    chk("post_ov", out_valid, 0);
    chk("post_busy", busy, 0);
  endtask

  task automatic idle_cycle(input bit clr, input bit spur);
    @(negedge clk);
    clr_err  = clr;
    eng_done = spur;
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_buf_we", buf_we, 0);
    @(posedge clk);
    if (clr) exp_err = 0;
    @(negedge clk);
    clr_err  = 1'b0;
    eng_done = 1'b0;
    #1;
    chk("idle_err", err_timeout, exp_err);
    chk("idle_stay", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b1;
    eng_done  = 1'b0;
    out_ready = 1'b0;
    clr_err   = 1'b0;
    #1;
    chk("r_ready", in_ready, 0);
    chk("r_start", eng_start, 0);
    chk("r_win_we", win_we, 0);
    chk("r_ov", out_valid, 0);
    chk("r_busy", busy, 0);
    chk("r_cnt", pixel_count, 0);
    chk("r_err", err_timeout, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    chk("rel_ready_lo", in_ready, 0);
    step();
    #1;
    chk("rel_ready", in_ready, 1);

    for (int i = 0; i < NL; i++) d[i] = 3;
    run_pixel(-1, -1, 10, 1'b0);

    for (int i = 0; i < NL; i++) d[i] = $urandom_range(1, TO);
    run_pixel(2, -1, 0, 1'b0);
    for (int i = 0; i < NL; i++) d[i] = $urandom_range(1, TO);
    run_pixel(-1, -1, 1, 1'b0);
    idle_cycle(1'b1, 1'b1);

    for (int i = 0; i < NL; i++) d[i] = 1;
    d[2] = TO;
    run_pixel(-1, -1, 0, 1'b0);
    chk("term_no_err", err_timeout, 0);

    for (int i = 0; i < NL; i++) d[i] = 2;
    run_pixel(1, -1, 0, 1'b1);

    for (int n = 0; n < 40; n++) begin
      int h;
      for (int i = 0; i < NL; i++) d[i] = $urandom_range(1, TO);
      h = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, NL - 1)) : -1;
      run_pixel(h, -1, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2))
        idle_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < NL; i++) d[i] = 1;
    while (exp_cnt != (1 << CW) - 1) run_pixel(-1, -1, 0, 1'b0);
    run_pixel(-1, -1, 2, 1'b0);
    chk("wrap", pixel_count, 0);

    for (int i = 0; i < NL; i++) d[i] = 5;
    run_pixel(-1, 3, 0, 1'b0);
    for (int i = 0; i < NL; i++) d[i] = 2;
    run_pixel(-1, -1, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
